// File: rtl/input_scheduler.sv
// input_scheduler: turns debounced button events into ship move pulses with auto-repeat,
// a req/ack fire sequencer with cooldown, and the pause toggle.
module input_scheduler #(
    parameter int REPEAT_DELAY  = 20,
    parameter int REPEAT_RATE   = 4,
    parameter int FIRE_COOLDOWN = 30,
    parameter int CNT_WIDTH     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       left_db,
    input  logic       left_press,
    input  logic       right_db,
    input  logic       right_press,
    input  logic       fire_press,
    input  logic       pause_press,
    input  logic       fire_ack,
    output logic       move_left,
    output logic       move_right,
    output logic       fire_req,
    output logic       paused,
    output logic [1:0] active_dir
);
    typedef enum logic [1:0] {M_IDLE, M_DELAY, M_REPEAT} mstate_t;
    typedef enum logic [1:0] {F_READY, F_REQ, F_COOL} fstate_t;

    localparam logic [CNT_WIDTH-1:0] DELAY_LAST = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] RATE_LAST  = CNT_WIDTH'(REPEAT_RATE - 1);
    localparam logic [CNT_WIDTH-1:0] COOL_LAST  = CNT_WIDTH'(FIRE_COOLDOWN - 1);

    mstate_t mstate, m_next;
    fstate_t fstate, f_next;
    logic [CNT_WIDTH-1:0] mcnt, mcnt_next, fcnt, fcnt_next;
    logic [1:0] dir_next, other_dir;
    logic left_next, right_next, req_next, released, other_db;

    assign released  = (active_dir == 2'd1 && !left_db) || (active_dir == 2'd2 && !right_db);
    assign other_db  = (active_dir == 2'd1) ? right_db : left_db;
    assign other_dir = (active_dir == 2'd1) ? 2'd2 : 2'd1;

    // Priority: pause > press (left over right) > release > tick.
    always_comb begin
        m_next     = mstate;
        mcnt_next  = mcnt;
        dir_next   = active_dir;
        left_next  = 1'b0;
        right_next = 1'b0;
        if (paused || pause_press) begin
            m_next    = M_IDLE;
            mcnt_next = '0;
            dir_next  = 2'd0;
        end else if (left_press || right_press) begin
            m_next     = M_DELAY;
            mcnt_next  = '0;
            dir_next   = left_press ? 2'd1 : 2'd2;
            left_next  = left_press;
            right_next = !left_press;
        end else if (released) begin
            m_next     = other_db ? M_DELAY : M_IDLE;
            mcnt_next  = '0;
            dir_next   = other_db ? other_dir : 2'd0;
            left_next  = other_db && other_dir == 2'd1;
            right_next = other_db && other_dir == 2'd2;
        end else if (tick && mstate != M_IDLE) begin
            if (mcnt == ((mstate == M_DELAY) ? DELAY_LAST : RATE_LAST)) begin
                m_next     = M_REPEAT;
                mcnt_next  = '0;
                left_next  = active_dir == 2'd1;
                right_next = active_dir == 2'd2;
            end else begin
                mcnt_next = mcnt + 1'b1;
            end
        end
    end

    // An outstanding request completes even while paused; cooldown freezes.
    always_comb begin
        f_next    = fstate;
        fcnt_next = fcnt;
        req_next  = fire_req;
        if (fstate == F_READY) begin
            if (fire_press && !paused && !pause_press) begin
                f_next   = F_REQ;
                req_next = 1'b1;
            end
        end else if (fstate == F_REQ) begin
            if (fire_ack) begin
                f_next    = F_COOL;
                fcnt_next = '0;
                req_next  = 1'b0;
            end
        end else if (tick && !paused) begin
            f_next    = (fcnt == COOL_LAST) ? F_READY : F_COOL;
            fcnt_next = (fcnt == COOL_LAST) ? fcnt : fcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mstate     <= M_IDLE;
            fstate     <= F_READY;
            mcnt       <= '0;
            fcnt       <= '0;
            move_left  <= 1'b0;
            move_right <= 1'b0;
            fire_req   <= 1'b0;
            paused     <= 1'b0;
            active_dir <= 2'd0;
        end else begin
            mstate     <= m_next;
            fstate     <= f_next;
            mcnt       <= mcnt_next;
            fcnt       <= fcnt_next;
            move_left  <= left_next;
            move_right <= right_next;
            fire_req   <= req_next;
            paused     <= paused ^ pause_press;
            active_dir <= dir_next;
        end
    end
endmodule

// File: tb/tb_input_scheduler.sv
// tb_input_scheduler: directed test-plan scenarios plus random traffic, every cycle
// checked against a tick-counting behavioural model.
module tb_input_scheduler;
    localparam int RD = 20, RR = 4, FC = 30;

    logic clk = 1'b0, reset = 1'b1, tick = 1'b0;
    logic left_db = 1'b0, left_press = 1'b0, right_db = 1'b0, right_press = 1'b0;
    logic fire_press = 1'b0, pause_press = 1'b0, fire_ack = 1'b0;
    logic move_left, move_right, fire_req, paused;
    logic [1:0] active_dir;

    int total = 0, bad = 0;

    // model state: direction held, ticks since its last pulse, whether the first repeat is pending
    int m_dir = 0, m_ticks = 0, f_mode = 0, f_left = 0;
    bit m_first = 0, e_left = 0, e_right = 0, e_req = 0, e_paused = 0;

    input_scheduler dut (
        .clk(clk), .reset(reset), .tick(tick), .left_db(left_db), .left_press(left_press),
        .right_db(right_db), .right_press(right_press), .fire_press(fire_press),
        .pause_press(pause_press), .fire_ack(fire_ack), .move_left(move_left),
        .move_right(move_right), .fire_req(fire_req), .paused(paused), .active_dir(active_dir)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    task automatic fresh(input int d);
        m_dir   = d;
        m_ticks = 0;
        m_first = 1;
        e_left  = (d == 1);
        e_right = (d == 2);
    endtask

    task automatic model_step();
        bit was_paused, dir_db, other_db;
        was_paused = e_paused;
        e_left = 0;
        e_right = 0;
        dir_db   = (m_dir == 1) ? left_db : right_db;
        other_db = (m_dir == 1) ? right_db : left_db;
        if (was_paused || pause_press) m_dir = 0;
        else if (left_press) fresh(1);
        else if (right_press) fresh(2);
        else if (m_dir != 0 && !dir_db) begin
            if (other_db) fresh(3 - m_dir);
            else m_dir = 0;
        end else if (m_dir != 0 && tick) begin
            m_ticks++;
            if (m_ticks == (m_first ? RD : RR)) begin
                m_ticks = 0;
                m_first = 0;
                e_left  = (m_dir == 1);
                e_right = (m_dir == 2);
            end
        end
        if (f_mode == 0) begin
            if (fire_press && !was_paused && !pause_press) begin
                f_mode = 1;
                e_req  = 1;
            end
        end else if (f_mode == 1) begin
            if (fire_ack) begin
                f_mode = 2;
                f_left = FC;
                e_req  = 0;
            end
        end else if (tick && !was_paused) begin
            f_left--;
            if (f_left == 0) f_mode = 0;
        end
        if (pause_press) e_paused = !e_paused;
    endtask

    task automatic compare_all();
        check("move_left", move_left, e_left);
        check("move_right", move_right, e_right);
        check("fire_req", fire_req, e_req);
        check("paused", paused, e_paused);
        check("active_dir", active_dir, m_dir);
    endtask

    task automatic cyc(input logic t, input logic lp, input logic rp, input logic fp,
                       input logic pp, input logic ak);
        tick = t; left_press = lp; right_press = rp;
        fire_press = fp; pause_press = pp; fire_ack = ak;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic tk();
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {tick, left_press, right_press, fire_press, pause_press, fire_ack} = '0;
        @(posedge clk);
        m_dir = 0; m_ticks = 0; m_first = 0; f_mode = 0; f_left = 0;
        e_left = 0; e_right = 0; e_req = 0; e_paused = 0;
        #1;
        check("rst_left", move_left, 0);
        check("rst_right", move_right, 0);
        check("rst_req", fire_req, 0);
        check("rst_paused", paused, 0);
        check("rst_dir", active_dir, 0);
        reset = 1'b0;
    endtask

    initial begin
        int n, first;
        int pulses[$];
        do_reset();

        // hold left for 30 ticks: pulses at press, 20, 24, 28
        left_db = 1;
        cyc(0, 1, 0, 0, 0, 0);
        if (move_left) pulses.push_back(0);
        for (int i = 1; i <= 30; i++) begin
            tk();
            if (move_left) pulses.push_back(i);
        end
        check("hold_pulse_cnt", pulses.size(), 4);
        if (pulses.size() == 4) begin
            check("hold_p0", pulses[0], 0);
            check("hold_p1", pulses[1], 20);
            check("hold_p2", pulses[2], 24);
            check("hold_p3", pulses[3], 28);
        end
        check("hold_dir", active_dir, 1);
        left_db = 0;
        cyc(0, 0, 0, 0, 0, 0);
        check("release_dir", active_dir, 0);
        check("release_nopulse", move_left, 0);

        // left held, right press, right release switches back to left
        left_db = 1;
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tk();
        right_db = 1;
        cyc(0, 0, 1, 0, 0, 0);
        check("right_pulse", move_right, 1);
        for (int i = 0; i < 5; i++) tk();
        right_db = 0;
        cyc(0, 0, 0, 0, 0, 0);
        check("switch_pulse", move_left, 1);
        check("switch_dir", active_dir, 1);
        first = -1;
        for (int i = 1; i <= 25; i++) begin
            tk();
            if (move_left && first < 0) first = i;
        end
        check("switch_next", first, 20);
        left_db = 0;
        cyc(0, 0, 0, 0, 0, 0);

        // fire handshake and cooldown
        n = 0;
        cyc(0, 0, 0, 1, 0, 0);
        if (fire_req) n++;
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            if (fire_req) n++;
        end
        cyc(0, 0, 0, 0, 0, 1);
        check("req_cycles", n, 3);
        check("req_dropped", fire_req, 0);
        for (int i = 1; i <= 29; i++) begin
            tk();
            if (i == 10) begin
                cyc(0, 0, 0, 1, 0, 0);
                check("cool_drop10", fire_req, 0);
            end
        end
        cyc(0, 0, 0, 1, 0, 0);
        check("cool_drop29", fire_req, 0);
        tk();
        cyc(0, 0, 0, 1, 0, 0);
        check("cool_done", fire_req, 1);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);

        // pause during cooldown freezes it
        for (int i = 0; i < 10; i++) tk();
        cyc(0, 0, 0, 0, 1, 0);
        check("pause_on", paused, 1);
        left_db = 1;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            tk();
            if (i % 7 == 0) cyc(0, 1, 0, 1, 0, 0);
            n += move_left + move_right + fire_req;
        end
        check("pause_quiet", n, 0);
        cyc(0, 0, 0, 0, 1, 0);
        check("pause_off", paused, 0);
        for (int i = 0; i < 19; i++) tk();
        check("no_resume", active_dir, 0);
        left_db = 0;
        cyc(0, 0, 0, 1, 0, 0);
        check("pause_cool19", fire_req, 0);
        tk();
        cyc(0, 0, 0, 1, 0, 0);
        check("pause_cool20", fire_req, 1);
        cyc(0, 0, 0, 0, 0, 1);

        // simultaneous presses
        left_db = 1; right_db = 1;
        cyc(0, 1, 1, 0, 0, 0);
        check("both_left", move_left, 1);
        check("both_right", move_right, 0);
        check("both_dir", active_dir, 1);
        left_db = 0;
        cyc(0, 0, 0, 0, 0, 0);
        right_db = 0;
        cyc(0, 0, 0, 0, 0, 0);
        left_db = 1;
        cyc(0, 1, 0, 0, 1, 0);
        check("lp_pause", paused, 1);
        check("lp_nopulse", move_left, 0);
        cyc(0, 1, 0, 0, 1, 0);
        check("unpause_drop", move_left, 0);

        // reset while firing in auto-repeat
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 30; i++) tk();
        cyc(0, 0, 0, 1, 0, 0);
        check("pre_rst_req", fire_req, 1);
        do_reset();
        cyc(0, 1, 0, 0, 0, 0);
        check("post_rst_press", move_left, 1);
        for (int i = 0; i < 20; i++) tk();
        left_db = 0;
        cyc(0, 0, 0, 0, 0, 0);

        // random traffic
        for (int i = 0; i < 6000; i++) begin
            logic t, lp, rp, fp, pp, ak;
            if ($urandom_range(0, 1999) == 0) begin
                do_reset();
                continue;
            end
            t = ($urandom_range(0, 2) == 0);
            lp = 0; rp = 0;
            if ($urandom_range(0, 39) == 0) begin left_db = ~left_db; lp = left_db; end
            if ($urandom_range(0, 39) == 0) begin right_db = ~right_db; rp = right_db; end
            if (left_db && $urandom_range(0, 79) == 0) lp = 1;
            if (right_db && $urandom_range(0, 79) == 0) rp = 1;
            fp = ($urandom_range(0, 14) == 0);
            pp = ($urandom_range(0, 149) == 0);
            ak = fire_req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            cyc(t, lp, rp, fp, pp, ak);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/input_scheduler.md
Name: input_scheduler

Overview:
- Turns debounced button events into game commands for the player ship.
- Produces move-step pulses with keyboard-style auto-repeat and arbitrates left against right.
- Sequences fire requests through a req/ack handshake with the missile engine, with a post-shot cooldown.
- Owns the pause toggle. It sits between the per-button debouncers and the game-logic core; all timing is counted in game ticks.

Parameters:
REPEAT_DELAY, 20, ticks from first step to first auto-repeat step
REPEAT_RATE, 4, ticks between auto-repeat steps
FIRE_COOLDOWN, 30, ticks after fire_ack before fire is accepted again
CNT_WIDTH, 8, tick counter width; every tick parameter must be >=1 and <=2^CNT_WIDTH

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tick  in  1  one-cycle game-time strobe
left_db  in  1  debounced left level
left_press  in  1  one-cycle left press event
right_db  in  1  debounced right level
right_press  in  1  one-cycle right press event
fire_press  in  1  one-cycle fire press event
pause_press  in  1  one-cycle pause press event
fire_ack  in  1  missile engine accepted the shot
move_left  out  1  one-cycle step-left pulse
move_right  out  1  one-cycle step-right pulse
fire_req  out  1  shot request level, held until acknowledged
paused  out  1  pause state level
active_dir  out  2  0 = none, 1 = left, 2 = right

Behaviour:
- All outputs are registered. On reset (sampled at a clk edge): every output is 0, move FSM = M_IDLE, fire FSM = F_READY, both counters = 0.
- Move FSM states: M_IDLE, M_DELAY, M_REPEAT. Counter mcnt.
  - left_press while not paused, in any state: active_dir=1, move_left pulses in the following cycle, mcnt=0, go to M_DELAY. right_press is handled the same way with active_dir=2.
  - left_press and right_press in the same cycle: left wins.
  - A press of the already-active direction restarts it: immediate pulse, then M_DELAY.
  - M_DELAY: on each tick, if mcnt==REPEAT_DELAY-1 then pulse, mcnt=0, go to M_REPEAT; otherwise mcnt++.
  - M_REPEAT: on each tick, if mcnt==REPEAT_RATE-1 then pulse and mcnt=0; otherwise mcnt++.
  - Active direction's db level goes low: if the other db level is high, switch active_dir to it, pulse immediately and go to M_DELAY with mcnt=0. Otherwise go to M_IDLE with active_dir=0. Release itself never produces a pulse.
  - Never pulse both directions in one cycle. At most one move pulse per clock cycle.
  - Press events take priority over a release detected in the same cycle.
- Fire FSM states: F_READY, F_REQ, F_COOL. Counter fcnt.
  - F_READY + fire_press + not paused: fire_req=1 from the next cycle, go to F_REQ.
  - F_REQ: hold fire_req until fire_ack is sampled high. In that same edge drop fire_req to 0, set fcnt=0, go to F_COOL.
  - F_COOL: on each tick, if fcnt==FIRE_COOLDOWN-1 go to F_READY; otherwise fcnt++.
  - fire_press in F_REQ or F_COOL is dropped; there is no queueing.
  - fire_ack outside F_REQ is ignored.
- Pause:
  - pause_press toggles paused, visible the next cycle.
  - Entering pause: move FSM goes to M_IDLE, active_dir=0, mcnt=0, and no move pulses are issued while paused.
  - During pause, an outstanding F_REQ still completes its handshake. F_COOL freezes, with ticks ignored.
  - Left, right and fire presses during pause are ignored. After unpause, movement restarts only on a new press; a held button does not resume.
  - pause_press arriving in the same cycle as other presses: pause takes effect and the other presses are dropped. When that pause_press is the one ending the pause, the simultaneous presses are also dropped.
- Counters are compared for equality only and never wrap past their terminal value.
- A tick arriving in the same cycle as a press: the press reset wins and that tick is not counted.
- Reset mid-operation aborts any handshake: fire_req drops the cycle after the reset edge.

Test Plan:
- Press left once, hold for 30 ticks, release (defaults) -> move_left pulses at the press, at tick 20 and at ticks 24 and 28; active_dir is 1 then 0; no pulse on release.
- Hold left, then press right, release right after 5 ticks while left is still held -> right pulse at the right press; on the right release, active_dir switches to 1 with an immediate left pulse; next left pulse comes 20 ticks later.
- fire_press, with fire_ack returned 3 cycles later, then fire_press at tick 10 and again at tick 30 -> fire_req is high for exactly 3 cycles; the press at tick 10 is dropped; the press at tick 30 raises fire_req again.
- Pause at cooldown tick 10, give 50 ticks, unpause -> paused=1; no move or fire activity; after unpause, cooldown resumes and needs 20 more ticks.
- left_press and right_press in the same cycle -> move_left pulses and active_dir=1. left_press together with pause_press -> paused=1 and no move pulse.
- Assert reset while fire_req=1 in M_REPEAT -> all outputs are 0 the cycle after the reset edge; the next left_press behaves as a fresh press.
